mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//   Upstream feeder for the 4x4 Vedic MAC stage: buffers streamed operand pairs in a small FIFO.
//   Runs a dot product of programmable length: clears the accumulator, issues one pair per cycle,
//     waits for the MAC register, then returns the 8-bit sum over a valid/ready result handshake.
// PARAMETERS
//   DW     4  operand width (a, b)
//   ACC_W  8  accumulator/result width (= 2*DW)
//   LEN_W  4  vector-length width; max length 2**LEN_W-1
//   DEPTH  4  operand FIFO depth (power of 2)
// PORTS
//   clk           in   1      clock
//   rst_n         in   1      reset, synchronous, active-low
//   in_valid      in   1      operand pair valid
//   in_ready      out  1      FIFO can accept (= !full)
//   in_a, in_b    in   DW     operand pair
//   start         in   1      begin a dot product (sampled in IDLE only)
//   vec_len       in   LEN_W  number of pairs, latched on start
//   mac_a, mac_b  out  DW     registered operands to MAC; 0 when not issuing
//   mac_clr       out  1      one-cycle accumulator clear pulse to MAC
//   acc_in        in   ACC_W  MAC accumulator output
//   result        out  ACC_W  captured dot product
//   result_valid  out  1      result held valid until accepted
//   result_ready  in   1      consumer accepts result
//   busy          out  1      state != IDLE
// BEHAVIOUR
//   Reset (rst_n low at clk edge): state IDLE, FIFO empty, mac_a/mac_b/result/count 0, mac_clr 0,
//     result_valid 0, busy 0; pushes ignored while rst_n low. Reset mid-run aborts with no result.
//   FIFO: push = in_valid & in_ready; pop only in RUN when !empty; push+pop same cycle keeps level.
//     No full bypass; in_ready low when full even if a pop occurs that cycle.
//   FSM: IDLE -start-> CLEAR (1 cyc, mac_clr=1, latch vec_len, count=0)
//     CLEAR -> RUN (vec_len!=0) | DRAIN (vec_len==0)
//     RUN: each cycle !empty -> pop, mac_a/b<=head, count++; empty -> mac_a/b<=0 (stall, product 0)
//       edge of pop making count==len_q -> DRAIN
//     DRAIN: 2 cycles, mac_a/b=0; second edge result<=acc_in, result_valid<=1 -> DONE
//     DONE: hold result; result_valid&result_ready -> IDLE, result_valid<=0
//   Latency: result_valid rises 2 edges after the last-pop edge; zero-length gives result 0
//     3 cycles after start.
//   start outside IDLE ignored; FIFO keeps accepting in every state.
//   Arithmetic: sum wraps modulo 2**ACC_W (MAC behaviour); sequencer does not alter acc_in.
// CONFIGURATION
//   MAC_SEQ_OVF_EN defined: adds output ovf (1 bit); shadow sum of products, ACC_W+LEN_W wide,
//     accumulated on each pop, cleared in CLEAR; ovf<=(shadow>=2**ACC_W) with result, held in DONE.
//   Undefined: no ovf port, no shadow logic.
// STRUCTURE
//   Package mac_seq_pkg: state enum {IDLE,CLEAR,RUN,DRAIN,DONE}, default DW/ACC_W/LEN_W constants.
//   Sub-module mac_seq_fifo (DEPTH x 2*DW, ptr+1 wrap bits, full/empty); FSM, counter top level.
// TESTING
//   Bench includes behavioural MAC model (acc <= acc + a*b, cleared by mac_clr).
//   len=3, pairs (2,3),(4,5),(1,1) preloaded, start -> result=27 (0x1B), valid 2 cyc after 3rd pop
//   len=2, pairs (15,15),(15,15) -> result=450 mod 256=194 (0xC2); with MAC_SEQ_OVF_EN ovf=1
//   len=0, start -> mac_clr pulse, result=0, result_valid 3 cycles after start
//   len=4, pairs fed with gaps (FIFO empty 2 cyc) -> stalls issue 0s, result=sum unchanged
//   5 pushes, no start, DEPTH=4 -> 5th held (in_ready=0); start len=4 -> 5th accepted on pop
//   Mid-RUN rst_n low 1 cycle -> IDLE, FIFO empty, result_valid 0; result_ready=0 holds result

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default sizes for the MAC dot-product sequencer.
package mac_seq_pkg;

    localparam int unsigned DefDw    = 4;
    localparam int unsigned DefAccW  = 8;
    localparam int unsigned DefLenW  = 4;
    localparam int unsigned DefDepth = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/mac_seq_fifo.sv
// Small synchronous FIFO holding operand pairs; pointers carry one extra wrap bit
// so full and empty can be told apart. No bypass: a full FIFO refuses a push even
// when a pop happens in the same cycle.
module mac_seq_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]      wr_ptr_q;
    logic [PtrW:0]      rd_ptr_q;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds operand pairs from a FIFO into the external MAC for a programmable-length
// dot product, then returns the accumulator over a valid/ready handshake.
// Optional feature macro: MAC_SEQ_OVF_EN adds an 'ovf' output flagging that the
// true (unwrapped) sum of products did not fit in ACC_W bits.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned DW    = DefDw,
    parameter int unsigned ACC_W = DefAccW,
    parameter int unsigned LEN_W = DefLenW,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
`ifdef MAC_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               drain_q, drain_d;
    logic [DW-1:0]      mac_a_q, mac_a_d;
    logic [DW-1:0]      mac_b_q, mac_b_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*DW-1:0]    fifo_rdata;
    logic [DW-1:0]      head_a;
    logic [DW-1:0]      head_b;

`ifdef MAC_SEQ_OVF_EN
    localparam int unsigned ShW = ACC_W + LEN_W;
    logic [ShW-1:0]     shadow_q, shadow_d;
    logic               ovf_q, ovf_d;
    logic [2*DW-1:0]    prod;

    assign prod = (2*DW)'(head_a) * (2*DW)'(head_b);
    assign ovf  = ovf_q;
`endif

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & ~fifo_full;
    assign head_a    = fifo_rdata[2*DW-1:DW];
    assign head_b    = fifo_rdata[DW-1:0];

    mac_seq_fifo #(
        .Width (2*DW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, issue and result-capture logic.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        count_d        = count_q;
        drain_d        = drain_q;
        mac_a_d        = '0;
        mac_b_d        = '0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        fifo_pop       = 1'b0;
`ifdef MAC_SEQ_OVF_EN
        shadow_d       = shadow_q;
        ovf_d          = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    len_d   = vec_len;
                    count_d = '0;
                end
            end
            StClear: begin
                drain_d = 1'b0;
`ifdef MAC_SEQ_OVF_EN
                shadow_d = '0;
`endif
                state_d = (len_q == '0) ? StDrain : StRun;
            end
            StRun: begin
                // An empty FIFO stalls issue; the MAC sees 0*0 that cycle.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mac_a_d  = head_a;
                    mac_b_d  = head_b;
                    count_d  = count_q + LEN_W'(1);
`ifdef MAC_SEQ_OVF_EN
                    shadow_d = shadow_q + ShW'(prod);
`endif
                    if (count_q + LEN_W'(1) == len_q) state_d = StDrain;
                end
            end
            StDrain: begin
                // First cycle lets the MAC register the last product.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d        = 1'b0;
                    result_d       = acc_in;
                    result_valid_d = 1'b1;
`ifdef MAC_SEQ_OVF_EN
                    ovf_d          = |shadow_q[ShW-1:ACC_W];
`endif
                    state_d        = StDone;
                end
            end
            StDone: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            len_q          <= '0;
            count_q        <= '0;
            drain_q        <= 1'b0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
`ifdef MAC_SEQ_OVF_EN
            shadow_q       <= '0;
            ovf_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            count_q        <= count_d;
            drain_q        <= drain_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
`ifdef MAC_SEQ_OVF_EN
            shadow_q       <= shadow_d;
            ovf_q          <= ovf_d;
`endif
        end
    end

    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_clr      = (state_q == StClear);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural MAC; table of dot-product runs
// plus hand-written FIFO-full, mid-run reset and result-hold sequences.
module tb_mac_dot_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       start;
    logic [3:0] vec_len;
    logic [3:0] mac_a;
    logic [3:0] mac_b;
    logic       mac_clr;
    logic [7:0] acc_in;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
`ifdef MAC_SEQ_OVF_EN
    logic       ovf;
`endif

    mac_dot_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .start        (start),
        .vec_len      (vec_len),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_clr      (mac_clr),
        .acc_in       (acc_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
`ifdef MAC_SEQ_OVF_EN
        .ovf          (ovf),
`endif
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural 4x4 MAC: wraps modulo 256.
    logic [7:0] acc_m;
    always @(posedge clk) begin
        if (mac_clr) acc_m <= 8'd0;
        else         acc_m <= acc_m + {4'd0, mac_a} * {4'd0, mac_b};
    end
    assign acc_in = acc_m;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int res;
        int ovf;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          len;
        logic [31:0] a_pk;     // nibble i = a of pair i
        logic [31:0] b_pk;
        int          preload;  // 1: push all pairs before start
        int          gap;      // idle cycles between pushes when streaming
        int          exp_res;
        int          exp_ovf;
        int          exp_lat;  // edges from start edge to result_valid, -1 = not checked
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
        int t;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        t        = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int len, input int res, input int ov);
        start   = 1'b1;
        vec_len = 4'(len);
        sb_q.push_back('{res: res, ovf: ov});
        @(negedge clk);
        start = 1'b0;
        check("clr_pulse", int'(mac_clr), 1);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_result(output int lat);
        sb_t e;
        lat = 0;
        while (!result_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!result_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got result_valid=0 expected 1 within 300 cycles");
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got result %0d expected no result", result);
        end else begin
            e = sb_q.pop_front();
            check("result", int'(result), e.res);
`ifdef MAC_SEQ_OVF_EN
            check("ovf", int'(ovf), e.ovf);
`endif
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        if (v.preload != 0) begin
            for (int i = 0; i < v.len; i++) push_pair(v.a_pk[4*i +: 4], v.b_pk[4*i +: 4]);
            do_start(v.len, v.exp_res, v.exp_ovf);
            wait_result(lat);
            if (v.exp_lat >= 0) check("latency", lat, v.exp_lat);
        end else begin
            do_start(v.len, v.exp_res, v.exp_ovf);
            for (int i = 0; i < v.len; i++) begin
                push_pair(v.a_pk[4*i +: 4], v.b_pk[4*i +: 4]);
                repeat (v.gap) @(negedge clk);
            end
            wait_result(lat);
        end
        @(negedge clk);
        check("idle_after_accept", int'(busy), 0);
        check("valid_cleared", int'(result_valid), 0);
    endtask

    initial begin
        int lat;

        vecs[0] = '{3, 32'h0000_0142, 32'h0000_0153, 1, 0, 27,  0, 6};
        vecs[1] = '{2, 32'h0000_00FF, 32'h0000_00FF, 1, 0, 194, 1, 5};
        vecs[2] = '{0, 32'h0000_0000, 32'h0000_0000, 1, 0, 0,   0, 3};
        vecs[3] = '{4, 32'h0000_1923, 32'h0000_5927, 0, 2, 111, 0, -1};
        vecs[4] = '{5, 32'h0009_7531, 32'h000A_8642, 0, 0, 190, 0, -1};
        vecs[5] = '{4, 32'h0000_FFFF, 32'h0000_FFFF, 1, 0, 132, 1, 7};
        vecs[6] = '{8, 32'h8765_4321, 32'h1111_1111, 0, 1, 36,  0, -1};

        // Reset with a push attempted while held; it must be dropped.
        rst_n        = 1'b0;
        in_valid     = 1'b1;
        in_a         = 4'd9;
        in_b         = 4'd9;
        start        = 1'b0;
        vec_len      = 4'd0;
        result_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_mac_a", int'(mac_a), 0);
        check("rst_mac_b", int'(mac_b), 0);
        check("rst_mac_clr", int'(mac_clr), 0);
        check("rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // FIFO full: fifth push held until the first pop frees a slot.
        push_pair(4'd1, 4'd1);
        push_pair(4'd2, 4'd2);
        push_pair(4'd3, 4'd3);
        push_pair(4'd4, 4'd4);
        check("full_ready_low", int'(in_ready), 0);
        in_a     = 4'd7;
        in_b     = 4'd7;
        in_valid = 1'b1;
        @(negedge clk);
        check("full_still_low", int'(in_ready), 0);
        do_start(4, 30, 0);
        check("full_in_clear", int'(in_ready), 0);
        @(negedge clk);
        check("full_no_bypass", int'(in_ready), 0);
        @(negedge clk);
        check("ready_after_pop", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        @(negedge clk);
        check("full_run_idle", int'(busy), 0);

        // Mid-run reset: the (7,7) left over plus two more starve a len-4 run.
        push_pair(4'd5, 4'd5);
        push_pair(4'd6, 4'd6);
        do_start(4, 0, 0);
        repeat (5) @(negedge clk);
        check("starve_busy", int'(busy), 1);
        check("stall_mac_a", int'(mac_a), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb_q.pop_back());  // aborted run produces no result
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(result_valid), 0);
        check("abort_mac_a", int'(mac_a), 0);
        check("abort_in_ready", int'(in_ready), 1);

        // FIFO must be empty: exactly four pushes fill it.
        push_pair(4'd2, 4'd3);
        push_pair(4'd3, 4'd3);
        push_pair(4'd1, 4'd4);
        check("empty_after_rst_3", int'(in_ready), 1);
        push_pair(4'd5, 4'd1);
        check("empty_after_rst_4", int'(in_ready), 0);

        // Result held while the consumer stalls.
        result_ready = 1'b0;
        do_start(4, 24, 0);
        wait_result(lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", int'(result_valid), 1);
            check("hold_result", int'(result), 24);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("hold_released", int'(result_valid), 0);
        check("hold_idle", int'(busy), 0);

        check("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
